// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge: CPU single-access port to a four-phase req/ack external bus.
// Ports: clk, reset (async, active-low); cpu_req/cpu_we/cpu_addr/cpu_wdata in,
// cpu_rdata/cpu_ready/bus_err out; mem_req/mem_we/mem_addr/mem_wdata out,
// mem_rdata/mem_ack in. Define EXT_BUS_TIMEOUT_EN to build the ack watchdog.
module ext_bus_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              mem_req_nx;
  logic              mem_we_nx;
  logic              ready_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic [DATA_W-1:0] rdata_nx;

`ifdef EXT_BUS_TIMEOUT_EN
  // wd counts ACCESS edges without ack; it equals n-1 on the n-th edge,
  // so the abort lands on the TIMEOUT-th ACCESS edge.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd;
  logic [7:0] wd_nx;
  logic       err_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd      <= '0;
      bus_err <= 1'b0;
    end else begin
      wd      <= wd_nx;
      bus_err <= err_nx;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, TIMEOUT};
  assign bus_err    = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    mem_req_nx = mem_req;
    mem_we_nx  = mem_we;
    addr_nx    = mem_addr;
    wdata_nx   = mem_wdata;
    rdata_nx   = cpu_rdata;
    ready_nx   = 1'b0;
`ifdef EXT_BUS_TIMEOUT_EN
    wd_nx      = wd;
    err_nx     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nx    = cpu_addr;
          mem_we_nx  = cpu_we;
          wdata_nx   = cpu_wdata;
          mem_req_nx = 1'b1;
          state_nx   = ACCESS;
`ifdef EXT_BUS_TIMEOUT_EN
          wd_nx      = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!mem_we) rdata_nx = mem_rdata;
          mem_req_nx = 1'b0;
          ready_nx   = 1'b1;
          state_nx   = RELEASE;
        end
`ifdef EXT_BUS_TIMEOUT_EN
        else if (wd == WD_LAST) begin
          if (!mem_we) rdata_nx = ERR_DATA;
          mem_req_nx = 1'b0;
          ready_nx   = 1'b1;
          err_nx     = 1'b1;
          state_nx   = RELEASE;
        end else begin
          wd_nx = wd + 8'd1;
        end
`endif
      end
      RELEASE: begin
        if (!mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      cpu_rdata <= rdata_nx;
      cpu_ready <= ready_nx;
    end
  end

endmodule

// File: doc/ext_bus_bridge.md
# ext_bus_bridge

Bridges the CPU's internal single-access memory port (address bus, data bus, read/write strobe) to an external memory or peripheral bus that uses a four-phase req/ack handshake with arbitrary wait states. The CPU core is the initiator and raises a request; this block is the responder on the CPU side. It holds the CPU with `cpu_ready` low until the external side completes. An optional watchdog terminates accesses that are never acknowledged.

## Interface

- `ADDR_W`, 16, address width (matches the 16-bit address bus).
- `DATA_W`, 8, data width (matches the 8-bit data bus).
- `TIMEOUT`, 15, cycles spent in ACCESS without `mem_ack` before abort; legal range 2..255.
- `ERR_DATA`, 8'hFF, read data returned on a timed-out read.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low (0 = in reset).
- `cpu_req`  input  1  access request level; held by CPU until `cpu_ready`.
- `cpu_we`  input  1  1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr`  input  ADDR_W  access address.
- `cpu_wdata`  input  DATA_W  write data.
- `cpu_rdata`  output  DATA_W  read data; valid when `cpu_ready`=1 and access was a read; holds until the next read completes.
- `cpu_ready`  output  1  one-cycle completion pulse.
- `bus_err`  output  1  one-cycle pulse coincident with `cpu_ready` on a timed-out access.
- `mem_req`  output  1  external request (four-phase).
- `mem_we`  output  1  external write enable, stable while `mem_req`=1.
- `mem_addr`  output  ADDR_W  external address, registered.
- `mem_wdata`  output  DATA_W  external write data, registered.
- `mem_rdata`  input  DATA_W  external read data, valid while `mem_ack`=1.
- `mem_ack`  input  1  external acknowledge.

## Operation

- FSM states: IDLE, ACCESS, RELEASE.
- IDLE: if `cpu_req`=1, register `cpu_addr`/`cpu_we`/`cpu_wdata` onto `mem_addr`/`mem_we`/`mem_wdata`, set `mem_req`=1, clear watchdog, go to ACCESS.
- ACCESS: if `mem_ack`=1, capture `mem_rdata` into `cpu_rdata` (reads only; writes leave `cpu_rdata` unchanged), set `mem_req`=0, pulse `cpu_ready`, go to RELEASE. Otherwise, increment the watchdog.
- Watchdog (with macro only): on the edge where the count reaches `TIMEOUT`-1 and `mem_ack`=0, set `mem_req`=0, load `ERR_DATA` on reads, pulse `cpu_ready` and `bus_err`, go to RELEASE. If `mem_ack` arrives on the same edge, the ack wins and there is no error.
- RELEASE: wait for `mem_ack`=0, then go to IDLE. `cpu_req` is ignored in this state.
- `mem_addr`/`mem_we`/`mem_wdata` are stable from `mem_req` rise until the next accepted request.
- A `cpu_req` still high when the FSM returns to IDLE starts a new access. The CPU must drop `cpu_req` or present the next access in the `cpu_ready` cycle.
- `cpu_addr` changes while not IDLE have no effect.
- Reset (any time, including mid-access): state IDLE; `mem_req`, `mem_we`, `cpu_ready`, `bus_err` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata`, watchdog = 0. An aborted access produces no `cpu_ready`.

## Timing

- Edge 0: `cpu_req` sampled in IDLE, so `mem_req` is high after edge 0.
- Earliest `mem_ack` sample is edge 1. `cpu_ready`/`cpu_rdata` are valid in the cycle after edge 1.
- With zero wait states, back-to-back access throughput is 1 access per 3 cycles: ACCESS, RELEASE, IDLE.
- Each cycle of `mem_ack` delay adds one cycle of latency. Each cycle `mem_ack` stays high after the drop of `mem_req` extends RELEASE by one cycle.
- Timeout: `cpu_ready`+`bus_err` are high in the cycle after the `TIMEOUT`-th ACCESS edge.
- All outputs are registered; no combinational path from `mem_*` inputs to `cpu_*` outputs.

## Configuration

- `EXT_BUS_TIMEOUT_EN` defined: watchdog, `bus_err` and `ERR_DATA` substitution are compiled in.
- Undefined: watchdog logic is removed, ACCESS waits indefinitely for `mem_ack`, `bus_err` is tied to 0, and `TIMEOUT`/`ERR_DATA` are unused.

## Test plan

- Reset: hold `reset`=0 with `cpu_req`=1 → all outputs 0, `mem_req` never rises. Release → first access starts on the next edge.
- Zero-wait read: model returns 8'h5A with ack one cycle after `mem_req` at address 16'h1234 → `mem_addr`=16'h1234, `cpu_rdata`=8'h5A with one-cycle `cpu_ready`, `bus_err`=0.
- Write with 3 wait states: address 16'hFFFE, data 8'hC3 → `mem_we`=1, `mem_wdata`=8'hC3 held 4 cycles, `cpu_rdata` unchanged, `mem_req` stays low until ack falls.
- Back-to-back: read 16'h0000 then write 16'h0001 with `cpu_req` held and ack echoing req → accesses complete 3 cycles apart, no lost or duplicated access.
- Timeout (macro on, `TIMEOUT`=15): read with `mem_ack` stuck 0 → `cpu_ready`+`bus_err` after 15 ACCESS cycles, `cpu_rdata`=8'hFF, `mem_req` low. Repeat with ack on cycle 15 → no error. Macro off → bench waits 100 cycles and sees no `cpu_ready`.
- Reset mid-access: assert `reset` during ACCESS → `mem_req` drops asynchronously, no `cpu_ready`, and the next access after reset completes normally.
